// File: rtl/rr_bus_arbiter_if.sv
// rr_bus_arbiter_if: request/data inputs and grant/bus outputs of the round-robin bus arbiter
interface rr_bus_arbiter_if #(parameter int N = 4, parameter int W = 8);
  logic [N-1:0]         req;
  logic [N*W-1:0]       data_in;
  logic [N-1:0]         grant;
  logic [$clog2(N)-1:0] owner;
  logic                 bus_valid;
  logic [W-1:0]         bus_out;
  modport master (output req, data_in, input grant, owner, bus_valid, bus_out);
  modport slave  (input req, data_in, output grant, owner, bus_valid, bus_out);
endinterface

// File: rtl/rr_bus_arbiter.sv
// rr_bus_arbiter: round-robin arbiter sharing one W-bit bus among N requesters with bounded tenure
module rr_bus_arbiter #(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int MAX_HOLD = 8
) (
  input  logic            clk,
  input  logic            resetn,
  rr_bus_arbiter_if.slave bus
);
  localparam int OW = $clog2(N);
  localparam int HW = MAX_HOLD > 1 ? $clog2(MAX_HOLD) : 1;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t          state, state_n;
  logic [N-1:0]    grant, grant_n;
  logic [OW-1:0]   owner, owner_n, ptr, ptr_n, start, pick, idx;
  logic [HW-1:0]   hold_cnt, hold_n;
  logic            found, rel;
  logic [W-1:0]    bus_out;
  // the downward scan lets the lowest rotation offset win, the current owner being scanned last
  always_comb begin
    start = state == BUSY ? OW'((int'(owner) + 1) % N) : ptr;
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = OW'((int'(start) + k) % N);
      if (bus.req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end
  always_comb begin
    rel     = state == IDLE || !bus.req[owner] || hold_cnt == HW'(MAX_HOLD - 1);
    state_n = state;
    grant_n = grant;
    owner_n = owner;
    ptr_n   = ptr;
    hold_n  = hold_cnt + 1'b1;
    if (rel) begin
      state_n = found ? BUSY : IDLE;
      grant_n = found ? N'(1) << pick : '0;
      owner_n = found ? pick : '0;
      ptr_n   = found ? OW'((int'(pick) + 1) % N) : ptr;
      hold_n  = '0;
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      grant    <= '0;
      owner    <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      grant    <= grant_n;
      owner    <= owner_n;
      ptr      <= ptr_n;
      hold_cnt <= hold_n;
    end
  end
  // masking by grant keeps non-owner data, even unknown, off the bus
  always_comb begin
    bus_out = '0;
    for (int i = 0; i < N; i++) bus_out = bus_out | (bus.data_in[i*W +: W] & {W{grant[i]}});
  end
  assign bus.grant     = grant;
  assign bus.owner     = owner;
  assign bus.bus_valid = |grant;
  assign bus.bus_out   = bus_out;
endmodule

// File: tb/tb_rr_bus_arbiter.sv
// tb_rr_bus_arbiter: directed and random stimulus against an integer round-robin reference model
module tb_rr_bus_arbiter;
  localparam int N = 4, W = 8, MAX_HOLD = 8;
  logic clk = 1'b0, resetn = 1'b0;
  int   errors = 0, checks = 0;
  int   m_own = -1, m_ptr = 0, m_hold = 0;
  rr_bus_arbiter_if #(.N(N), .W(W)) bif ();
  rr_bus_arbiter #(.N(N), .W(W), .MAX_HOLD(MAX_HOLD)) dut (.clk(clk), .resetn(resetn), .bus(bif));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_own = -1; m_ptr = 0; m_hold = 0;
  endtask
  // tenure ends when the owner drops or has used MAX_HOLD cycles; next winner is first requester after the scan start
  task automatic model_edge(input logic [N-1:0] r);
    int s, w;
    if (m_own < 0 || !r[m_own] || m_hold == MAX_HOLD - 1) begin
      s = m_own < 0 ? m_ptr : (m_own + 1) % N;
      w = -1;
      for (int k = 0; k < N && w < 0; k++) if (r[(s + k) % N]) w = (s + k) % N;
      m_own = w; m_hold = 0;
      if (w >= 0) m_ptr = (w + 1) % N;
    end else m_hold++;
  endtask
  task automatic check_all(input string tag);
    logic [N-1:0] eg;
    logic [W-1:0] eb;
    eg = m_own < 0 ? '0 : N'(1) << m_own;
    eb = m_own < 0 ? '0 : bif.data_in[m_own*W +: W];
    chk({tag, "_grant"}, 32'(bif.grant), 32'(eg));
    chk({tag, "_owner"}, 32'(bif.owner), m_own < 0 ? 0 : m_own);
    chk({tag, "_valid"}, 32'(bif.bus_valid), m_own < 0 ? 0 : 1);
    chk({tag, "_bus"}, 32'(bif.bus_out), 32'(eb));
    chk({tag, "_onehot"}, 32'($onehot0(bif.grant)), 1);
  endtask
  task automatic step(input string tag);
    logic [N-1:0] r;
    @(posedge clk);
    r = bif.req;
    if (resetn) model_edge(r);
    #1;
    check_all(tag);
  endtask
  task automatic rand_data();
    for (int i = 0; i < N; i++) bif.data_in[i*W +: W] = W'($urandom);
  endtask
  task automatic do_reset();
    #2 resetn = 1'b0;
    model_reset();
    #1 check_all("reset");
    #2 resetn = 1'b1;
  endtask
  initial begin
    bif.req = '0;
    rand_data();
    #3 check_all("reset0");
    @(posedge clk); #1 resetn = 1'b1;
    for (int c = 0; c < 20; c++) begin rand_data(); step("idle"); end
    bif.data_in[2*W +: W] = 8'hA5;
    bif.req = 4'b0100;
    step("single");
    chk("single_grant_c", 32'(bif.grant), 32'h4);
    chk("single_bus_c", 32'(bif.bus_out), 32'hA5);
    bif.req = 4'b0000;
    step("single_drop");
    chk("single_drop_c", 32'(bif.bus_out), 32'h0);
    do_reset();
    bif.req = 4'b1111;
    for (int c = 1; c <= 40; c++) begin
      step("rot");
      chk("rot_order", 32'(bif.owner), ((c - 1) / MAX_HOLD) % N);
      rand_data();
    end
    bif.req = 4'b0010;
    for (int c = 0; c < 20; c++) begin
      step("sole");
      chk("sole_grant", 32'(bif.grant), 32'h2);
      rand_data();
    end
    do_reset();
    bif.req = 4'b1000;
    step("own3");
    chk("own3_c", 32'(bif.grant), 32'h8);
    bif.req = 4'b0101;
    step("wrap");
    chk("wrap_c", 32'(bif.grant), 32'h1);
    do_reset();
    bif.req = 4'b0100;
    step("pre_async");
    chk("pre_async_c", 32'(bif.grant), 32'h4);
    #3 resetn = 1'b0;
    model_reset();
    #1 check_all("async");
    chk("async_bus_c", 32'(bif.bus_out), 32'h0);
    #2 resetn = 1'b1;
    bif.req = 4'b0110;
    step("post_async");
    chk("post_async_c", 32'(bif.grant), 32'h2);
    for (int c = 0; c < 400; c++) begin
      bif.req = ($urandom_range(0, 3) == 0) ? N'($urandom) : bif.req;
      if ($urandom_range(0, 7) == 0) bif.req[bif.owner] = 1'b0;
      rand_data();
      step("rand");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
